// File: rtl/cdc_2phase_serv_pkg.sv
// rtl/cdc_2phase_serv_pkg.sv - shared constants and helpers for the two-phase destination FIFO
package cdc_2phase_serv_pkg;

   localparam int SYNC_STAGES = 2;

   function automatic int fill_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_serv.sv
// rtl/sync_serv.sv - single-bit flop-chain synchronizer, async active-low reset to 0
module sync_serv
   import cdc_2phase_serv_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* async_reg = "true", dont_touch = "true" *) logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_2phase_dst_fifo_serv.sv
// rtl/cdc_2phase_dst_fifo_serv.sv - two-phase req/ack receiver into a DEPTH-entry FIFO; CDC_2PHASE_SERV_FILL_EN adds fill_o
module cdc_2phase_dst_fifo_serv
   import cdc_2phase_serv_pkg::*;
#(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_req_i,
   input  T     async_data_i,
   output logic async_ack_o,
   output T     data_o,
   output logic valid_o,
   input  logic ready_i
`ifdef CDC_2PHASE_SERV_FILL_EN
   ,
   output logic [fill_width(DEPTH)-1:0] fill_o
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = fill_width(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("DEPTH must be a power of two and at least 2");
   end

   logic             req_s1;
   logic             seen_q;
   logic             ack_q;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;
   T                 mem [DEPTH];
   logic             push;
   logic             pop;

   sync_serv u_req_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .d     (async_req_i),
      .q     (req_s1)
   );

   // Full check uses the start-of-cycle count, so a pop never frees a slot for the same edge.
   assign push = (req_s1 != seen_q) && (count < CNT_W'(DEPTH));
   assign pop  = valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seen_q <= 1'b0;
         ack_q  <= 1'b0;
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            seen_q <= req_s1;
            ack_q  <= ~ack_q;
            wptr   <= wptr + PTR_W'(1);
         end
         if (pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // async_data_i is only sampled once req_s1 shows the toggle, by which time it has been stable for two edges.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr] <= async_data_i;
      end
   end

   assign async_ack_o = ack_q;
   assign valid_o     = (count != '0);
   assign data_o      = mem[rptr];

`ifdef CDC_2PHASE_SERV_FILL_EN
   assign fill_o = count;
`endif

endmodule

// File: tb/tb_cdc_2phase_dst_fifo_serv.sv
// tb/tb_cdc_2phase_dst_fifo_serv.sv - randomized self-checking bench; fill_o checks under CDC_2PHASE_SERV_FILL_EN
module tb_cdc_2phase_dst_fifo_serv;

   typedef logic [7:0] byte_t;
   localparam int DEPTH = 4;

   logic  clk;
   logic  rst_n;
   logic  req;
   byte_t data;
   logic  ack;
   byte_t dout;
   logic  valid;
   logic  ready;
`ifdef CDC_2PHASE_SERV_FILL_EN
   logic [2:0] fill;
`endif

   int    vectors;
   int    errors;
   byte_t exp_q[$];
   int    model_cnt;
   logic  prev_ack;

   cdc_2phase_dst_fifo_serv #(.T(byte_t), .DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .async_req_i  (req),
      .async_data_i (data),
      .async_ack_o  (ack),
      .data_o       (dout),
      .valid_o      (valid),
      .ready_i      (ready)
`ifdef CDC_2PHASE_SERV_FILL_EN
      ,
      .fill_o       (fill)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; scores any pop against the reference queue and tracks occupancy from acks.
   task automatic tick();
      logic  did_pop;
      byte_t seen;
      did_pop = valid && ready;
      seen    = dout;
      @(posedge clk);
      #1;
      if (did_pop) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_empty: popped %0h with nothing expected", seen);
         end else begin
            if (seen !== exp_q[0]) begin
               errors++;
               $display("FAIL pop_data: got %0h want %0h", seen, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         model_cnt--;
      end
      if (ack !== prev_ack) begin
         model_cnt++;
         prev_ack = ack;
      end
      vectors++;
      if (valid !== (model_cnt != 0)) begin
         errors++;
         $display("FAIL valid_track: got %0b want %0b", valid, model_cnt != 0);
      end
`ifdef CDC_2PHASE_SERV_FILL_EN
      vectors++;
      if (fill !== 3'(model_cnt)) begin
         errors++;
         $display("FAIL fill_track: got %0d want %0d", fill, model_cnt);
      end
`endif
   endtask

   task automatic send(input byte_t d);
      data = d;
      req  = ~req;
      exp_q.push_back(d);
   endtask

   task automatic wait_ack(input int bound, input string name);
      for (int i = 0; i < bound && ack !== req; i++) tick();
      vectors++;
      if (ack !== req) begin
         errors++;
         $display("FAIL %s: ack %0b want %0b within %0d cycles", name, ack, req, bound);
      end
   endtask

   task automatic drain(input string name);
      ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      ready = 1'b0;
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d items left undelivered, want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      data  = 8'h00;
      ready = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      prev_ack  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (valid !== 1'b0 || ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid %0b ack %0b want 0 0", valid, ack);
      end
`ifdef CDC_2PHASE_SERV_FILL_EN
      vectors++;
      if (fill !== 3'd0) begin
         errors++;
         $display("FAIL reset_fill: got %0d want 0", fill);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      send(8'hA5);
      for (int e = 1; e <= 2; e++) begin
         tick();
         vectors++;
         if (valid !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL single_early: edge %0d valid %0b ack %0b want 0 0", e, valid, ack);
         end
      end
      tick();
      vectors++;
      if (valid !== 1'b1 || dout !== 8'hA5 || ack !== 1'b1) begin
         errors++;
         $display("FAIL single_edge3: valid %0b data %0h ack %0b want 1 a5 1", valid, dout, ack);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      vectors++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: valid %0b want 0", valid);
      end
   endtask

   task automatic test_fill();
      logic held_ack;
      ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(byte_t'(i));
         wait_ack(10, "fill_ack");
      end
      vectors++;
      if (model_cnt != 4 || valid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full: count %0d valid %0b want 4 1", model_cnt, valid);
      end
`ifdef CDC_2PHASE_SERV_FILL_EN
      vectors++;
      if (fill !== 3'd4) begin
         errors++;
         $display("FAIL fill_o_full: got %0d want 4", fill);
      end
`endif
      held_ack = ack;
      send(8'h05);
      repeat (8) tick();
      vectors++;
      if (ack !== held_ack) begin
         errors++;
         $display("FAIL fill_held: ack %0b want %0b", ack, held_ack);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      vectors++;
      if (ack !== held_ack) begin
         errors++;
         $display("FAIL fill_no_passthru: ack %0b want %0b", ack, held_ack);
      end
      tick();
      vectors++;
      if (ack !== ~held_ack) begin
         errors++;
         $display("FAIL fill_release: ack %0b want %0b", ack, ~held_ack);
      end
      drain("fill_drain");
   endtask

   task automatic test_order();
      int sent;
      sent = 0;
      for (int c = 0; c < 600 && !(sent == 16 && exp_q.size() == 0); c++) begin
         if (ack === req && sent < 16) begin
            send(byte_t'(sent));
            sent++;
         end
         ready = 1'($urandom_range(0, 1));
         tick();
      end
      ready = 1'b0;
      vectors++;
      if (sent != 16 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL order_complete: sent %0d pending %0d want 16 0", sent, exp_q.size());
      end
   endtask

   task automatic test_simul();
      byte_t a;
      byte_t b;
      a = byte_t'($urandom);
      b = byte_t'($urandom);
      ready = 1'b0;
      send(a);
      wait_ack(10, "simul_ack_a");
      send(b);
      wait_ack(10, "simul_ack_b");
      send(byte_t'($urandom));
      tick();
      tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      vectors++;
      if (ack !== req || model_cnt != 2 || dout !== b) begin
         errors++;
         $display("FAIL simul_push_pop: ack %0b count %0d data %0h want %0b 2 %0h", ack, model_cnt, dout, req, b);
      end
`ifdef CDC_2PHASE_SERV_FILL_EN
      vectors++;
      if (fill !== 3'd2) begin
         errors++;
         $display("FAIL simul_fill: got %0d want 2", fill);
      end
`endif
      drain("simul_drain");
   endtask

   task automatic test_reset_mid();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(byte_t'($urandom));
         wait_ack(10, "mid_ack");
      end
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      vectors++;
      if (valid !== 1'b0 || ack !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid %0b ack %0b want 0 0", valid, ack);
      end
`ifdef CDC_2PHASE_SERV_FILL_EN
      vectors++;
      if (fill !== 3'd0) begin
         errors++;
         $display("FAIL mid_reset_fill: got %0d want 0", fill);
      end
`endif
      @(posedge clk);
      #1;
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      prev_ack  = 1'b0;
      rst_n = 1'b1;
      repeat (4) tick();
      send(8'h3C);
      wait_ack(10, "mid_ack_new");
      vectors++;
      if (valid !== 1'b1 || dout !== 8'h3C) begin
         errors++;
         $display("FAIL mid_new_item: valid %0b data %0h want 1 3c", valid, dout);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      vectors++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_alone: valid %0b want 0", valid);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_single();
      test_fill();
      test_order();
      test_simul();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cdc_2phase_dst_fifo_serv.md
CDC_2PHASE_DST_FIFO_SERV -- requirements
Module: cdc_2phase_dst_fifo_serv

Interface
REQ-001 The block SHALL have parameter T: type, default logic, meaning the payload type.
REQ-002 The block SHALL have parameter DEPTH: int, default 4, meaning the FIFO entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  destination clock; the block has one clock, with all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- async_req_i  in  1  two-phase request from the remote source; each level toggle means a new item.
- async_data_i  in  $bits(T)  payload; stable while a request is outstanding.
- async_ack_o  out  1  two-phase acknowledge to the remote source; each toggle returns one credit.
- data_o  out  $bits(T)  head-of-FIFO payload.
- valid_o  out  1  the FIFO is non-empty.
- ready_i  in  1  the consumer accepts data_o.
- fill_o  out  $clog2(DEPTH+1)  occupancy; present only under CDC_2PHASE_SERV_FILL_EN.

Function
REQ-004 async_req_i SHALL pass through a two-flop synchronizer (req_s0, req_s1) before any use; async_data_i SHALL NOT be synchronized.
REQ-005 A register seen_q SHALL hold the phase of the last request that was captured.
- An item is pending when req_s1 != seen_q.
REQ-006 Push SHALL occur when an item is pending and count < DEPTH at the start of the cycle.
- Push writes async_data_i to mem[wptr].
- Push increments wptr modulo DEPTH.
- Push sets seen_q to req_s1.
- Push toggles ack_q; async_ack_o = ack_q.
REQ-007 When the FIFO is full, a pending item SHALL wait; async_ack_o SHALL hold until a slot frees.
- There is no same-cycle pop-to-push pass-through.
REQ-008 Pop SHALL occur on valid_o && ready_i, and increments rptr modulo DEPTH.
- valid_o = (count != 0).
- data_o = mem[rptr], driven from registers with no combinational path from async_data_i.
REQ-009 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-010 Latency SHALL be exactly 3 clk_i edges from an async_req_i toggle (set up before edge 1) to valid_o high on an empty FIFO.
- async_ack_o toggles on the same edge that valid_o rises.
REQ-011 At most one item SHALL be pushed per remote toggle.
- A second toggle is not acted on until seen_q has matched the first.
- Correct two-phase operation by the source guarantees this.
REQ-012 Throughput SHALL be one push per cycle when pushes are not back-to-back-limited by the source, and one pop per cycle.

Reset
REQ-013 On rst_ni low, the following SHALL clear to 0 immediately:
- req_s0, req_s1, seen_q, ack_q
- wptr, rptr, count
REQ-014 Reset values SHALL be: async_ack_o=0, valid_o=0, fill_o=0; mem content is don't-care, with data_o=mem[0].
REQ-015 Reset mid-transfer SHALL discard all buffered items.
- The remote source must be reset in the same reset event.
- A request toggled during reset is ignored.

Configuration
REQ-016 When CDC_2PHASE_SERV_FILL_EN is defined, port fill_o SHALL exist and equal count.
REQ-017 When CDC_2PHASE_SERV_FILL_EN is undefined, fill_o SHALL be absent; all other behaviour is identical.

Structure
REQ-018 Package cdc_2phase_serv_pkg SHALL hold:
- the constant SYNC_STAGES = 2
- the function fill_width(depth) = $clog2(depth+1)
REQ-019 Sub-module sync_serv SHALL be a single-bit SYNC_STAGES flop chain with asynchronous active-low reset to 0.
- Its flops carry async_reg and dont_touch attributes.
- The block instantiates it once, for async_req_i.

Verification
REQ-020 Single transfer: reset, data=0xA5, toggle req 0->1 -> valid_o=1 and data_o=0xA5 at edge 3, async_ack_o=1 at the same edge; ready_i=1 -> valid_o=0 next cycle.
REQ-021 Fill: DEPTH=4, ready_i=0, source sends 0x01..0x05 -> four acks, fill_o=4; fifth item is held with ack unchanged; one pop -> fifth item is captured and ack toggles.
REQ-022 Ordering: 16 items 0x00..0x0F with random ready_i -> output order is identical, with no loss or duplication across pointer wrap.
REQ-023 Simultaneous push and pop at count=2 -> count stays 2, data_o advances to the next item.
REQ-024 Reset with 3 items buffered -> valid_o=0, async_ack_o=0, fill_o=0 while rst_ni is low; after release, a new item 0x3C arrives alone.
REQ-025 Build without CDC_2PHASE_SERV_FILL_EN -> compiles without fill_o; REQ-020..REQ-024 responses unchanged.
